// File: rtl/rv_bus_arb.sv
// Two-master (fetch, load/store) to one-slave memory bus arbiter with registered request path.
// Optional fetch anti-starvation: define RV_ARB_FAIR_EN.
module rv_bus_arb #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int TIMEOUT      = 255,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_fetch_req,
    input  logic [ADDR_W-1:0]   i_fetch_addr,
    output logic                o_fetch_ack,
    output logic                o_fetch_err,
    output logic [DATA_W-1:0]   o_fetch_rdata,
    input  logic                i_data_req,
    input  logic                i_data_we,
    input  logic [DATA_W/8-1:0] i_data_sel,
    input  logic [ADDR_W-1:0]   i_data_addr,
    input  logic [DATA_W-1:0]   i_data_wdata,
    output logic                o_data_ack,
    output logic                o_data_err,
    output logic [DATA_W-1:0]   o_data_rdata,
    output logic                o_bus_cyc,
    output logic                o_bus_stb,
    output logic                o_bus_we,
    output logic [DATA_W/8-1:0] o_bus_sel,
    output logic [ADDR_W-1:0]   o_bus_addr,
    output logic [DATA_W-1:0]   o_bus_wdata,
    input  logic                i_bus_ack,
    input  logic [DATA_W-1:0]   i_bus_rdata,
    output logic                o_owner
);

    localparam int SEL_W    = DATA_W / 8;
    localparam int TMO_BITS = $clog2(TIMEOUT + 1);
    localparam int STV_BITS = $clog2(STARVE_LIMIT + 1);
    // One width wide enough for the watchdog and the starve counter, never below 8 bits.
    localparam int MAX_BITS = (TMO_BITS > STV_BITS) ? TMO_BITS : STV_BITS;
    localparam int CNT_W    = (MAX_BITS > 8) ? MAX_BITS : 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_F = 2'd1,
        GNT_D = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                cyc_q, cyc_d;
    logic                we_q, we_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                owner_q, owner_d;
    logic [CNT_W-1:0]    tmo_q, tmo_d;
`ifdef RV_ARB_FAIR_EN
    logic [CNT_W-1:0]    starve_q, starve_d;
`endif

    logic force_f;
    logic grant_d;
    logic grant_f;
    logic tmo_hit;

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        owner_d = owner_q;
        tmo_d   = tmo_q;
`ifdef RV_ARB_FAIR_EN
        starve_d = starve_q;
        force_f  = i_fetch_req && (starve_q == CNT_W'(STARVE_LIMIT));
`else
        force_f  = 1'b0;
`endif
        grant_d = i_data_req && !force_f;
        grant_f = i_fetch_req && !grant_d;
        // Ack in the expiry cycle takes precedence over the error completion.
        tmo_hit = (TIMEOUT != 0) && (state_q != IDLE) && !i_bus_ack
                  && (tmo_q == CNT_W'(TIMEOUT));

        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = GNT_D;
                    cyc_d   = 1'b1;
                    owner_d = 1'b1;
                    we_d    = i_data_we;
                    sel_d   = i_data_sel;
                    addr_d  = i_data_addr;
                    wdata_d = i_data_wdata;
                    tmo_d   = '0;
                end else if (grant_f) begin
                    state_d = GNT_F;
                    cyc_d   = 1'b1;
                    owner_d = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = '1;
                    addr_d  = i_fetch_addr;
                    wdata_d = '0;
                    tmo_d   = '0;
                end
`ifdef RV_ARB_FAIR_EN
                if (grant_f) begin
                    starve_d = '0;
                end else if (grant_d && i_fetch_req) begin
                    starve_d = starve_q + CNT_W'(1);
                end
`endif
            end
            GNT_F, GNT_D: begin
                if (i_bus_ack || tmo_hit) begin
                    state_d = IDLE;
                    cyc_d   = 1'b0;
                end else begin
                    tmo_d = tmo_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q  <= IDLE;
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            owner_q  <= 1'b0;
            tmo_q    <= '0;
`ifdef RV_ARB_FAIR_EN
            starve_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            owner_q  <= owner_d;
            tmo_q    <= tmo_d;
`ifdef RV_ARB_FAIR_EN
            starve_q <= starve_d;
`endif
        end
    end

    // Completions are suppressed while reset is asserted so an aborted transfer never acks.
    assign o_fetch_ack   = i_reset_n && (state_q == GNT_F) && i_bus_ack;
    assign o_fetch_err   = i_reset_n && (state_q == GNT_F) && tmo_hit;
    assign o_data_ack    = i_reset_n && (state_q == GNT_D) && i_bus_ack;
    assign o_data_err    = i_reset_n && (state_q == GNT_D) && tmo_hit;
    assign o_fetch_rdata = i_bus_rdata;
    assign o_data_rdata  = i_bus_rdata;

    assign o_bus_cyc   = cyc_q;
    assign o_bus_stb   = cyc_q;
    assign o_bus_we    = we_q;
    assign o_bus_sel   = sel_q;
    assign o_bus_addr  = addr_q;
    assign o_bus_wdata = wdata_q;
    assign o_owner     = owner_q;

endmodule
